// File: rtl/mul_div_unit.sv
// Multi-cycle RV32M execution unit: MUL/MULH/MULHSU/MULHU via a retimeable 33x33 multiply,
// DIV/REM via 32-step restoring division on operand magnitudes, with the pipeline held in stall.
module mul_div_unit #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MUL_LAT   = 2,
    parameter int unsigned ALUOP_WID = 4,
    parameter logic [ALUOP_WID-1:0] ALU_MUL    = ALUOP_WID'(10),
    parameter logic [ALUOP_WID-1:0] ALU_MULH   = ALUOP_WID'(11),
    parameter logic [ALUOP_WID-1:0] ALU_MULHSU = ALUOP_WID'(12),
    parameter logic [ALUOP_WID-1:0] ALU_MULHU  = ALUOP_WID'(13),
    parameter logic [ALUOP_WID-1:0] ALU_DIV    = ALUOP_WID'(14),
    parameter logic [ALUOP_WID-1:0] ALU_REM    = ALUOP_WID'(15)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ALUOP_WID-1:0] alu_op,
    input  logic [DATA_W-1:0]    src1,
    input  logic [DATA_W-1:0]    src2,
    input  logic                 flush,
    output logic                 stall,
    output logic                 done,
    output logic [DATA_W-1:0]    result
);
    localparam int unsigned CNT_W = (MUL_LAT > DATA_W) ? $clog2(MUL_LAT) : $clog2(DATA_W);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ALUOP_WID-1:0] op_q, op_d;
    logic [DATA_W-1:0]    opa_q, opa_d;
    logic [DATA_W-1:0]    opb_q, opb_d;
    logic [DATA_W-1:0]    rem_q, rem_d;
    logic                 qneg_q, qneg_d;
    logic                 rneg_q, rneg_d;
    logic [DATA_W-1:0]    result_q, result_d;

    logic                 is_mul, is_div, accept, div_zero, div_ovf;
    logic [DATA_W-1:0]    a_abs, b_abs;
    logic [DATA_W:0]      ma, mb;
    logic [2*DATA_W-1:0]  prod;
    logic [DATA_W-1:0]    mul_res;
    logic [DATA_W:0]      trial, diff;
    logic                 q_bit;
    logic [DATA_W-1:0]    new_rem, new_quo, quo_fin, rem_fin;

    always_comb begin
        is_mul   = (alu_op == ALU_MUL) || (alu_op == ALU_MULH) ||
                   (alu_op == ALU_MULHSU) || (alu_op == ALU_MULHU);
        is_div   = (alu_op == ALU_DIV) || (alu_op == ALU_REM);
        accept   = start && !flush && (is_mul || is_div) &&
                   ((state_q == S_IDLE) || (state_q == S_DONE));
        a_abs    = src1[DATA_W-1] ? (~src1 + 1'b1) : src1;
        b_abs    = src2[DATA_W-1] ? (~src2 + 1'b1) : src2;
        div_zero = (src2 == '0);
        div_ovf  = (src1 == {1'b1, {(DATA_W-1){1'b0}}}) && (src2 == '1);

        // 33-bit operands cover every signedness combination; 64-bit wrap keeps the product exact
        ma      = {opa_q[DATA_W-1] && ((op_q == ALU_MULH) || (op_q == ALU_MULHSU)), opa_q};
        mb      = {opb_q[DATA_W-1] && (op_q == ALU_MULH), opb_q};
        prod    = {{(DATA_W-1){ma[DATA_W]}}, ma} * {{(DATA_W-1){mb[DATA_W]}}, mb};
        mul_res = (op_q == ALU_MUL) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];

        // opa_q doubles as the dividend/quotient shift register during division
        trial   = {rem_q, opa_q[DATA_W-1]};
        diff    = trial - {1'b0, opb_q};
        q_bit   = !diff[DATA_W];
        new_rem = q_bit ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
        new_quo = {opa_q[DATA_W-2:0], q_bit};
        quo_fin = qneg_q ? (~new_quo + 1'b1) : new_quo;
        rem_fin = rneg_q ? (~new_rem + 1'b1) : new_rem;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        rem_d    = rem_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;

        unique case (state_q)
            S_MUL: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    result_d = mul_res;
                end
            end
            S_DIV: begin
                opa_d = new_quo;
                rem_d = new_rem;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    result_d = (op_q == ALU_DIV) ? quo_fin : rem_fin;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            op_d   = alu_op;
            qneg_d = src1[DATA_W-1] ^ src2[DATA_W-1];
            rneg_d = src1[DATA_W-1];
            if (is_mul) begin
                state_d = S_MUL;
                cnt_d   = CNT_W'(MUL_LAT - 1);
                opa_d   = src1;
                opb_d   = src2;
            end else if (div_zero) begin
                state_d  = S_DONE;
                result_d = (alu_op == ALU_DIV) ? '1 : src1;
            end else if (div_ovf) begin
                state_d  = S_DONE;
                result_d = (alu_op == ALU_DIV) ? src1 : '0;
            end else begin
                state_d = S_DIV;
                cnt_d   = CNT_W'(DATA_W - 1);
                opa_d   = a_abs;
                opb_d   = b_abs;
                rem_d   = '0;
            end
        end

        if (flush) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            rem_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            rem_q    <= rem_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign stall  = (state_q == S_MUL) || (state_q == S_DIV) || accept;
    assign done   = (state_q == S_DONE);
    assign result = result_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table for results/latency plus flush, reset,
// back-to-back and non-MDU sequences.
module tb_mul_div_unit;
    localparam logic [3:0] OP_MUL    = 4'd10;
    localparam logic [3:0] OP_MULH   = 4'd11;
    localparam logic [3:0] OP_MULHSU = 4'd12;
    localparam logic [3:0] OP_MULHU  = 4'd13;
    localparam logic [3:0] OP_DIV    = 4'd14;
    localparam logic [3:0] OP_REM    = 4'd15;
    localparam int         NVEC      = 17;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[NVEC];

    mul_div_unit #(
        .DATA_W(32), .MUL_LAT(2), .ALUOP_WID(4),
        .ALU_MUL(OP_MUL), .ALU_MULH(OP_MULH), .ALU_MULHSU(OP_MULHSU),
        .ALU_MULHU(OP_MULHU), .ALU_DIV(OP_DIV), .ALU_REM(OP_REM)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .src1(src1), .src2(src2),
        .flush(flush), .stall(stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, id, act, exp);
        end
    endtask

    // Called at a sampling point (just after a falling edge); returns at the DONE cycle.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input int id);
        int c;
        bit got;
        start = 1'b1; alu_op = op; src1 = a; src2 = b;
        #1;
        check("stall_accept", id, 32'(stall), 32'd1);
        c = 0;
        got = 1'b0;
        while (!got && c < 100) begin
            @(negedge clk);
            c++;
            start = 1'b0; alu_op = 4'd0; src1 = $urandom; src2 = $urandom;
            #1;
            if (done) got = 1'b1;
            else check("stall_busy", id, 32'(stall), 32'd1);
        end
        check("latency", id, 32'(c), 32'(lat));
        check("result", id, result, exp);
        check("stall_done", id, 32'(stall), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 3};
        vecs[1]  = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 3};
        vecs[2]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 3};
        vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 3};
        vecs[4]  = '{OP_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 3};
        vecs[5]  = '{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 3};
        vecs[6]  = '{OP_MULHU,  32'h80000000, 32'h00000002, 32'h00000001, 3};
        vecs[7]  = '{OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
        vecs[8]  = '{OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
        vecs[9]  = '{OP_DIV,    32'd100,      32'd7,        32'd14,       33};
        vecs[10] = '{OP_REM,    32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 33};
        vecs[11] = '{OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
        vecs[12] = '{OP_REM,    32'h80000000, 32'd3,        32'hFFFFFFFE, 33};
        vecs[13] = '{OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[14] = '{OP_REM,    32'd5,        32'd0,        32'd5,        1};
        vecs[15] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[16] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1};

        rst = 1'b1; start = 1'b0; alu_op = 4'd0; src1 = '0; src2 = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_stall", 0, 32'(stall), 32'd0);
        check("reset_done", 0, 32'(done), 32'd0);
        check("reset_result", 0, result, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, i);
            @(negedge clk);
            #1;
            check("idle_done", i, 32'(done), 32'd0);
        end

        // non-MDU op with start: ignored
        start = 1'b1; alu_op = 4'd3; src1 = 32'd1; src2 = 32'd2;
        #1;
        check("nonmdu_stall", 0, 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("nonmdu_done", 0, 32'(done), 32'd0);
        check("nonmdu_stall2", 0, 32'(stall), 32'd0);
        check("nonmdu_result", 0, result, 32'd0);

        // flush a division on cycle 10, restart a MUL on cycle 11
        start = 1'b1; alu_op = OP_DIV; src1 = 32'd100; src2 = 32'd7;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            start = 1'b0; alu_op = 4'd0;
            flush = (c == 10);
            #1;
            check("flush_no_done", c, 32'(done), 32'd0);
            if (c == 11) check("flush_stall", c, 32'(stall), 32'd0);
        end
        run_op(OP_MUL, 32'd3, 32'd4, 32'd12, 3, 100);

        // back-to-back: DIV accepted in the DONE cycle of a MUL
        @(negedge clk);
        #1;
        run_op(OP_MUL, 32'd6, 32'd7, 32'd42, 3, 101);
        check("b2b_first_done", 101, 32'(done), 32'd1);
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 102);

        // flush while in DONE: done still visible, then idle
        @(negedge clk);
        #1;
        run_op(OP_MUL, 32'd2, 32'd3, 32'd6, 3, 103);
        flush = 1'b1;
        #1;
        check("flushdone_done", 103, 32'(done), 32'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flushdone_idle", 103, 32'(done), 32'd0);
        check("flushdone_result", 103, result, 32'd6);

        // synchronous reset mid-division
        start = 1'b1; alu_op = OP_DIV; src1 = 32'd1000; src2 = 32'd3;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0; alu_op = 4'd0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid_stall", 0, 32'(stall), 32'd0);
        check("rstmid_result", 0, result, 32'd0);
        for (int c = 0; c < 40; c++) begin
            check("rstmid_no_done", c, 32'(done), 32'd0);
            @(negedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
